// File: rtl/muldiv_unit.sv
// muldiv_unit: multiply/divide unit for the execute stage.
//
// One operation is accepted at a time over in_valid/in_ready. The result is
// returned over out_valid/out_ready.
// - Multiplies: the full product is formed from the operands at accept and
//   registered. The result reaches DONE MUL_STAGES cycles after accept.
// - Divides: radix-2 restoring iteration on magnitudes. It runs for WIDTH
//   cycles, then one sign fix-up cycle, then DONE (WIDTH+2 cycles).
// - flush returns the unit to IDLE from any state and drops any pending
//   result.
//
// Optional build macro: MULDIV_EARLY_OUT_EN. When it is defined, a divide
// with a zero divisor, or with |dividend| < |divisor|, finishes two cycles
// after accept. The results are the same as on the full iteration path.
//
// Ports:
//   clk, resetn             clock (rising edge), async active-low reset
//   in_valid/in_ready       request handshake
//   in_op[2:0]              0 MUL, 1 MULH, 2 MULHU, 3 DIV, 4 MOD, 5 DIVU, 6 MODU, 7 = MUL
//   in_src1/in_src2         multiplicand/dividend, multiplier/divisor
//   flush                   abort the in-flight op
//   out_valid/out_ready     result handshake
//   out_result              result, held stable while out_valid && !out_ready
//   busy                    state is not IDLE
module muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_src1,
    input  logic [WIDTH-1:0] in_src2,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [2:0] OP_MULH  = 3'd1;
    localparam logic [2:0] OP_MULHU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_MOD   = 3'd4;
    localparam logic [2:0] OP_MODU  = 3'd6;
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + ONE) : v;
    endfunction

    function automatic logic [WIDTH-1:0] mul_pick(input logic [2:0] op, input logic [2*WIDTH-1:0] p);
        return ((op == OP_MULH) || (op == OP_MULHU)) ? p[2*WIDTH-1:WIDTH] : p[WIDTH-1:0];
    endfunction

    function automatic logic is_rem_op(input logic [2:0] op);
        return (op == OP_MOD) || (op == OP_MODU);
    endfunction

    state_t             state_q, state_d, state_nx_s;
    logic [2:0]         op_q, op_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;     // holds |dividend| on entry, quotient when done
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic               acc_is_div_s, acc_sdiv_s, s1_neg_s, s2_neg_s, mul_sx_s;
    logic [WIDTH-1:0]   abs1_s, abs2_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH:0]     div_tmp_s;
    logic               div_ge_s;
    logic [WIDTH-1:0]   div_sub_s;
`ifdef MULDIV_EARLY_OUT_EN
    logic               early_s;
    logic [WIDTH-1:0]   early_res_s;
`endif

    // in_ready is gated by resetn so that every output reads 0 while reset is held.
    assign in_ready   = resetn && (state_q == S_IDLE) && !flush;
    assign out_valid  = out_valid_q;
    assign out_result = res_q;
    assign busy       = busy_q;

    // Accept-time operand decode: divide magnitudes/signs and the full product.
    always_comb begin
        acc_is_div_s = (in_op >= OP_DIV) && (in_op <= OP_MODU);
        acc_sdiv_s   = (in_op == OP_DIV) || (in_op == OP_MOD);
        s1_neg_s     = acc_sdiv_s && in_src1[WIDTH-1];
        s2_neg_s     = acc_sdiv_s && in_src2[WIDTH-1];
        abs1_s       = neg_if(in_src1, s1_neg_s);
        abs2_s       = neg_if(in_src2, s2_neg_s);
        mul_sx_s     = (in_op == OP_MULH);
        // The product of the 2*WIDTH-bit extensions (sign or zero) is exact modulo 2^(2*WIDTH).
        prod_s = {{WIDTH{mul_sx_s && in_src1[WIDTH-1]}}, in_src1} *
                 {{WIDTH{mul_sx_s && in_src2[WIDTH-1]}}, in_src2};
    end

    // One restoring-division step. The shifted-in dividend bit comes from the top of quo_q.
    always_comb begin
        div_tmp_s = {rem_q, quo_q[WIDTH-1]};
        div_ge_s  = (div_tmp_s >= {1'b0, dvs_q});
        // The true difference is always below 2^WIDTH, so the low bits are enough.
        div_sub_s = div_tmp_s[WIDTH-1:0] - dvs_q;
    end

`ifdef MULDIV_EARLY_OUT_EN
    // Early-out detection on the magnitudes latched at accept.
    always_comb begin
        early_s     = (dvs_q == ZERO) || (quo_q < dvs_q);
        early_res_s = is_rem_op(op_q) ? neg_if(quo_q, r_neg_q) :
                      ((dvs_q == ZERO) ? ONES : ZERO);
    end
`endif

    // Next-state and datapath update, before the flush override.
    always_comb begin
        state_nx_s = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        prod_d     = prod_q;
        res_d      = res_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    op_d  = in_op;
                    cnt_d = {CW{1'b0}};
                    if (acc_is_div_s) begin
                        state_nx_s = S_DIV;
                        rem_d      = ZERO;
                        quo_d      = abs1_s;
                        dvs_d      = abs2_s;
                        // Divide by zero keeps the all-ones quotient whatever the dividend sign.
                        q_neg_d    = (s1_neg_s ^ s2_neg_s) && (in_src2 != ZERO);
                        r_neg_d    = s1_neg_s;
                    end else if (MUL_STAGES == 1) begin
                        state_nx_s = S_DONE;
                        res_d      = mul_pick(in_op, prod_s);
                    end else begin
                        state_nx_s = S_MUL;
                        prod_d     = prod_s;
                    end
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_MUL: begin
                if (cnt_q == CW'(MUL_STAGES - 2)) begin
                    state_nx_s = S_DONE;
                    res_d      = mul_pick(op_q, prod_q);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DIV: begin
`ifdef MULDIV_EARLY_OUT_EN
                if ((cnt_q == {CW{1'b0}}) && early_s) begin
                    state_nx_s = S_DONE;
                    res_d      = early_res_s;
                end else
`endif
                begin
                    rem_d = div_ge_s ? div_sub_s : div_tmp_s[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], div_ge_s};
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_nx_s = S_FIX;
                        cnt_d      = {CW{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_FIX: begin
                state_nx_s = S_DONE;
                res_d      = is_rem_op(op_q) ? neg_if(rem_q, r_neg_q) : neg_if(quo_q, q_neg_q);
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_DONE;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // Flush override and the registered status outputs derived from the next state.
    always_comb begin
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            state_d = state_nx_s;
        end
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            op_q        <= 3'd0;
            cnt_q       <= {CW{1'b0}};
            rem_q       <= ZERO;
            quo_q       <= ZERO;
            dvs_q       <= ZERO;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            prod_q      <= {(2*WIDTH){1'b0}};
            res_q       <= ZERO;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            prod_q      <= prod_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

endmodule
